// File: rtl/srl_sched_pkg.sv
// Shared types and defaults for the SRL test scheduler.
// Optional build macro SRL_SCHED_LOOP_EN is consumed by srl_test_scheduler.
package srl_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReset,
    StWarmup,
    StRun,
    StNext,
    StDone
  } sched_state_e;

  localparam int unsigned NumChDefault       = 8;
  localparam int unsigned PrescalerDefault   = 4;
  localparam int unsigned RstCyclesDefault   = 4;
  localparam int unsigned WarmupTicksDefault = 64;
  localparam int unsigned RunTicksDefault    = 256;

  // Counter width that never collapses to zero bits.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/srl_test_scheduler_if.sv
// Control/status and tester-bank signals of the SRL test scheduler.
// master = board side (switches, testers' error lines), slave = scheduler.
interface srl_test_scheduler_if
  import srl_sched_pkg::*;
#(
  parameter int unsigned NUM_CH = NumChDefault
);
  localparam int unsigned ChW = cnt_width(NUM_CH);

  logic              start;
  logic              abort;
  logic [NUM_CH-1:0] err_in;
  logic [NUM_CH-1:0] tester_rst;
  logic [NUM_CH-1:0] tester_ce;
  logic [ChW-1:0]    cur_ch;
  logic              busy;
  logic              done;
  logic [NUM_CH-1:0] fail_mask;

  modport master (
    output start, abort, err_in,
    input  tester_rst, tester_ce, cur_ch, busy, done, fail_mask
  );

  modport slave (
    input  start, abort, err_in,
    output tester_rst, tester_ce, cur_ch, busy, done, fail_mask
  );

endinterface

// File: rtl/srl_sched_prescaler.sv
// Shift-tick prescaler: counts while enabled, tick on PRESCALER-1 then wraps.
// Synchronous clear has priority over enable.
module srl_sched_prescaler
  import srl_sched_pkg::*;
#(
  parameter int unsigned PRESCALER = PrescalerDefault
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int unsigned CntW = cnt_width(PRESCALER);
  localparam logic [CntW-1:0] CntLast = CntW'(PRESCALER - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/srl_test_scheduler.sv
// Time-shares a bank of SRL chain testers: per channel reset, warm-up, measured run.
// Define SRL_SCHED_LOOP_EN to sweep continuously with a done pulse per wrap.
module srl_test_scheduler
  import srl_sched_pkg::*;
#(
  parameter int unsigned NUM_CH       = NumChDefault,
  parameter int unsigned PRESCALER    = PrescalerDefault,
  parameter int unsigned RST_CYCLES   = RstCyclesDefault,
  parameter int unsigned WARMUP_TICKS = WarmupTicksDefault,
  parameter int unsigned RUN_TICKS    = RunTicksDefault
) (
  input logic                 clk,
  input logic                 rst_n,
  srl_test_scheduler_if.slave bus
);
  localparam int unsigned ChW      = cnt_width(NUM_CH);
  localparam int unsigned MaxTicks = (WARMUP_TICKS > RUN_TICKS) ? WARMUP_TICKS : RUN_TICKS;
  localparam int unsigned TickW    = cnt_width(MaxTicks);
  localparam int unsigned RstW     = cnt_width(RST_CYCLES);

  localparam logic [ChW-1:0]   ChLast   = ChW'(NUM_CH - 1);
  localparam logic [TickW-1:0] WarmLast = TickW'(WARMUP_TICKS - 1);
  localparam logic [TickW-1:0] RunLast  = TickW'(RUN_TICKS - 1);
  localparam logic [RstW-1:0]  RstLast  = RstW'(RST_CYCLES - 1);

  sched_state_e      state_q, state_d;
  logic [ChW-1:0]    cur_ch_q, cur_ch_d;
  logic [RstW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [TickW-1:0]  tick_cnt_q, tick_cnt_d;
  logic [NUM_CH-1:0] err_q;
  logic              run_dly_q, run_dly_d;
  logic [NUM_CH-1:0] fail_q, fail_d;
  logic [NUM_CH-1:0] tester_rst_q, tester_rst_d;
  logic [NUM_CH-1:0] tester_ce_q, tester_ce_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        rst_sync_q;
  logic              clr_fail;
  logic              presc_en;
  logic              tick;
`ifdef SRL_SCHED_LOOP_EN
  logic              wrap;
`endif

  assign presc_en = (state_q == StWarmup) || (state_q == StRun);

  srl_sched_prescaler #(
    .PRESCALER (PRESCALER)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!presc_en),
    .en    (presc_en),
    .tick  (tick)
  );

  always_comb begin
    state_d    = state_q;
    cur_ch_d   = cur_ch_q;
    rst_cnt_d  = rst_cnt_q;
    tick_cnt_d = tick_cnt_q;
    fail_d     = fail_q;
    clr_fail   = 1'b0;
`ifdef SRL_SCHED_LOOP_EN
    wrap       = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        // Hold off until the reset deassertion has passed the synchronizer.
        if (bus.start && rst_sync_q[1]) begin
          state_d  = StReset;
          cur_ch_d = '0;
          clr_fail = 1'b1;
        end
      end
      StReset: begin
        if (rst_cnt_q == RstLast) begin
          state_d    = StWarmup;
          rst_cnt_d  = '0;
          tick_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      StWarmup: begin
        if (tick) begin
          if (tick_cnt_q == WarmLast) begin
            state_d    = StRun;
            tick_cnt_d = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      StRun: begin
        if (tick) begin
          if (tick_cnt_q == RunLast) begin
            state_d    = StNext;
            tick_cnt_d = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      StNext: begin
        if (cur_ch_q == ChLast) begin
`ifdef SRL_SCHED_LOOP_EN
          state_d  = StReset;
          cur_ch_d = '0;
          wrap     = 1'b1;
`else
          state_d  = StDone;
`endif
        end else begin
          state_d  = StReset;
          cur_ch_d = cur_ch_q + 1'b1;
        end
      end
      StDone: begin
        if (bus.start) begin
          state_d  = StReset;
          cur_ch_d = '0;
          clr_fail = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // err_q and run_dly_q are both one clock late, so the window matches RUN exactly.
    if (run_dly_q && err_q[cur_ch_q]) begin
      fail_d[cur_ch_q] = 1'b1;
    end
    if (clr_fail) begin
      fail_d = '0;
    end

    if (bus.abort) begin
      state_d    = StIdle;
      cur_ch_d   = '0;
      rst_cnt_d  = '0;
      tick_cnt_d = '0;
`ifdef SRL_SCHED_LOOP_EN
      wrap       = 1'b0;
`endif
    end

    run_dly_d = (state_q == StRun) && !bus.abort;
    busy_d    = state_d inside {StReset, StWarmup, StRun, StNext};
`ifdef SRL_SCHED_LOOP_EN
    done_d    = wrap;
`else
    done_d    = (state_d == StDone);
`endif

    tester_rst_d = '1;
    if (state_d inside {StWarmup, StRun, StNext}) begin
      tester_rst_d[cur_ch_d] = 1'b0;
    end

    tester_ce_d = '0;
    if (tick && !bus.abort) begin
      tester_ce_d[cur_ch_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q   <= 2'b00;
      state_q      <= StIdle;
      cur_ch_q     <= '0;
      rst_cnt_q    <= '0;
      tick_cnt_q   <= '0;
      err_q        <= '0;
      run_dly_q    <= 1'b0;
      fail_q       <= '0;
      tester_rst_q <= '1;
      tester_ce_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      rst_sync_q   <= {rst_sync_q[0], 1'b1};
      state_q      <= state_d;
      cur_ch_q     <= cur_ch_d;
      rst_cnt_q    <= rst_cnt_d;
      tick_cnt_q   <= tick_cnt_d;
      err_q        <= bus.err_in;
      run_dly_q    <= run_dly_d;
      fail_q       <= fail_d;
      tester_rst_q <= tester_rst_d;
      tester_ce_q  <= tester_ce_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.tester_rst = tester_rst_q;
  assign bus.tester_ce  = tester_ce_q;
  assign bus.cur_ch     = cur_ch_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.fail_mask  = fail_q;

endmodule

// File: tb/tb_srl_test_scheduler.sv
// Directed bench for srl_test_scheduler: 4 channels, 101 clocks per channel.
module tb_srl_test_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   t = 0;
  int   n_total = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  int   ce_cnt [4];
  int   busy_cnt;

  always #5 clk = ~clk;

  srl_test_scheduler_if #(.NUM_CH(4)) bus ();

  srl_test_scheduler #(
    .NUM_CH       (4),
    .PRESCALER    (4),
    .RST_CYCLES   (4),
    .WARMUP_TICKS (8),
    .RUN_TICKS    (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic goto(input int target);
    while (t < target) step();
  endtask

  // t=0 is the first clock after start was sampled (channel 0 RESET).
  task automatic start_sweep();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    t = 0;
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus.err_in = 4'b0000;
    #12;
    check("rst_tester_rst", 32'(bus.tester_rst), 32'hf);
    check("rst_tester_ce", 32'(bus.tester_ce), 32'h0);
    check("rst_cur_ch", 32'(bus.cur_ch), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_fail", 32'(bus.fail_mask), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) step();

`ifdef SRL_SCHED_LOOP_EN
    start_sweep();
    check("loop_busy", 32'(bus.busy), 32'h1);
    goto(252);
    bus.err_in[2] = 1'b1;
    step();
    bus.err_in[2] = 1'b0;
    goto(404);
    check("loop_done1", 32'(bus.done), 32'h1);
    check("loop_busy1", 32'(bus.busy), 32'h1);
    check("loop_ch0", 32'(bus.cur_ch), 32'h0);
    check("loop_fail1", 32'(bus.fail_mask), 32'h4);
    step();
    check("loop_done_pulse", 32'(bus.done), 32'h0);
    goto(808);
    check("loop_done2", 32'(bus.done), 32'h1);
    check("loop_fail2", 32'(bus.fail_mask), 32'h4);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("loop_abort_busy", 32'(bus.busy), 32'h0);
    check("loop_abort_fail", 32'(bus.fail_mask), 32'h4);
`else
    // Clean sweep: pulse counts, busy duration and done.
    for (int k = 0; k < 4; k++) ce_cnt[k] = 0;
    busy_cnt = 0;
    start_sweep();
    for (int i = 0; i < 404; i++) begin
      if (bus.busy === 1'b1) busy_cnt++;
      for (int k = 0; k < 4; k++) if (bus.tester_ce[k] === 1'b1) ce_cnt[k]++;
      if (i == 0) check("sweep_reset_rst", 32'(bus.tester_rst), 32'hf);
      if (i == 4) check("ch0_warm_rst", 32'(bus.tester_rst), 32'he);
      if (i == 7) check("ch0_ce_early", 32'(bus.tester_ce), 32'h0);
      if (i == 8) check("ch0_ce_first", 32'(bus.tester_ce), 32'h1);
      if (i == 105) check("ch1_warm_rst", 32'(bus.tester_rst), 32'hd);
      if (i == 105) check("ch1_cur_ch", 32'(bus.cur_ch), 32'h1);
      step();
    end
    check("clean_busy_cnt", 32'(busy_cnt), 32'd404);
    check("clean_done", 32'(bus.done), 32'h1);
    check("clean_busy_low", 32'(bus.busy), 32'h0);
    check("clean_fail", 32'(bus.fail_mask), 32'h0);
    check("done_all_rst", 32'(bus.tester_rst), 32'hf);
    for (int k = 0; k < 4; k++) check($sformatf("ce_cnt%0d", k), 32'(ce_cnt[k]), 32'd24);
    repeat (5) step();
    check("done_held", 32'(bus.done), 32'h1);

    // Warm-up errors ignored, run error caught, non-selected channel ignored.
    bus.err_in[3] = 1'b1;
    start_sweep();
    goto(150);
    check("err_before", 32'(bus.fail_mask), 32'h0);
    goto(151);
    bus.err_in[1] = 1'b1;
    step();
    bus.err_in[1] = 1'b0;
    goto(154);
    check("err_ch1_run", 32'(bus.fail_mask), 32'h2);
    goto(206);
    bus.err_in[2] = 1'b1;
    step();
    bus.err_in[2] = 1'b0;
    goto(237);
    bus.err_in[2] = 1'b1;
    step();
    bus.err_in[2] = 1'b0;
    goto(250);
    check("err_ch2_warm", 32'(bus.fail_mask), 32'h2);
    goto(404);
    bus.err_in[3] = 1'b0;
    check("err_done", 32'(bus.done), 32'h1);
    check("err_fail", 32'(bus.fail_mask), 32'ha);

    // Restart clears mask; last-RUN-clock error; abort mid-RUN.
    start_sweep();
    check("restart_clear", 32'(bus.fail_mask), 32'h0);
    goto(99);
    bus.err_in[0] = 1'b1;
    step();
    bus.err_in[0] = 1'b0;
    goto(101);
    check("last_run_err", 32'(bus.fail_mask), 32'h1);
    goto(252);
    check("ch2_run_rst", 32'(bus.tester_rst), 32'hb);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'h0);
    check("abort_done", 32'(bus.done), 32'h0);
    check("abort_rst", 32'(bus.tester_rst), 32'hf);
    check("abort_ce", 32'(bus.tester_ce), 32'h0);
    check("abort_ch", 32'(bus.cur_ch), 32'h0);
    check("abort_fail", 32'(bus.fail_mask), 32'h1);
    repeat (2) step();
    check("abort_idle", 32'(bus.busy), 32'h0);

    // Start while busy ignored; start+abort together goes idle.
    start_sweep();
    check("idle_start_clear", 32'(bus.fail_mask), 32'h0);
    goto(120);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("busy_start_busy", 32'(bus.busy), 32'h1);
    check("busy_start_ch", 32'(bus.cur_ch), 32'h1);
    goto(130);
    check("busy_start_rst", 32'(bus.tester_rst), 32'hd);
    goto(160);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    step();
    check("both_busy", 32'(bus.busy), 32'h0);
    check("both_rst", 32'(bus.tester_rst), 32'hf);
    step();
    check("both_idle_busy", 32'(bus.busy), 32'h0);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    step();
`endif

    // Async reset mid-RUN, then synchronizer delay before a sweep can start.
    start_sweep();
    goto(40);
    bus.err_in[0] = 1'b1;
    step();
    bus.err_in[0] = 1'b0;
    goto(48);
    check("pre_arst_fail", 32'(bus.fail_mask), 32'h1);
    goto(50);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rst", 32'(bus.tester_rst), 32'hf);
    check("arst_ce", 32'(bus.tester_ce), 32'h0);
    check("arst_ch", 32'(bus.cur_ch), 32'h0);
    check("arst_busy", 32'(bus.busy), 32'h0);
    check("arst_done", 32'(bus.done), 32'h0);
    check("arst_fail", 32'(bus.fail_mask), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.start = 1'b1;
    step();
    check("sync_edge1", 32'(bus.busy), 32'h0);
    step();
    check("sync_edge2", 32'(bus.busy), 32'h0);
    step();
    check("sync_edge3", 32'(bus.busy), 32'h1);
    bus.start = 1'b0;
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/srl_test_scheduler.md
# srl_test_scheduler

Sequencer that time-shares a bank of SRL chain testers on one clock domain. Channels run one after another: reset, shift-clock warm-up, then a measured run. The block generates each channel's prescaled shift tick and reset, and collects a sticky per-channel fail mask. It sits between the board-level switches/LEDs and the array of SRL shift testers, replacing free-running per-tester ticks.

## Interface
- `NUM_CH`, 8: number of tester channels (1..16).
- `PRESCALER`, 4: clocks per shift tick (≥2).
- `RST_CYCLES`, 4: clocks the selected tester is held in reset (≥1).
- `WARMUP_TICKS`, 64: ticks with errors ignored, to fill the SRL chains (≥1).
- `RUN_TICKS`, 256: ticks with errors sampled (≥1).

Ports:
- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: level sampled each clock; begins a sweep from IDLE or DONE.
- `abort` in 1: returns to IDLE from any state.
- `err_in` in NUM_CH: per-channel tester error outputs.
- `tester_rst` out NUM_CH: per-channel tester reset, active high.
- `tester_ce` out NUM_CH: per-channel one-clock shift tick.
- `cur_ch` out $clog2(NUM_CH) (min 1): channel under test.
- `busy` out 1: a sweep is in progress.
- `done` out 1: sweep complete; held until the next start or abort.
- `fail_mask` out NUM_CH: sticky per-channel failure flags.

## Operation
- States:
  - IDLE → RESET on `start`.
  - RESET, for RST_CYCLES clocks → WARMUP.
  - WARMUP, for WARMUP_TICKS·PRESCALER clocks → RUN.
  - RUN, for RUN_TICKS·PRESCALER clocks → NEXT.
  - NEXT, 1 clock → RESET with `cur_ch`+1, or DONE if `cur_ch`==NUM_CH−1.
  - DONE → RESET with `cur_ch`=0 on `start`.
- `tester_rst[k]`=1 for every k≠`cur_ch`, and for all k in IDLE, DONE and RESET. It is 0 only for `cur_ch` in WARMUP, RUN and NEXT.
- Prescaler counter:
  - Cleared on entry to WARMUP and free-running through RUN.
  - `tick` is asserted when the counter is PRESCALER−1, then the counter wraps to 0.
  - `tester_ce` = onehot(`cur_ch`) & `tick`, and only in WARMUP or RUN.
- `fail_mask[cur_ch]` is set on any clock in RUN where `err_in[cur_ch]`=1. Errors in other states, and errors on non-selected channels, are ignored.
- Start from IDLE or DONE clears `fail_mask` and sets `cur_ch`=0. `start` while busy is ignored.
- `abort` takes effect next clock: state=IDLE, `cur_ch`=0, all `tester_rst`=1, `tester_ce`=0, `done`=0. `fail_mask` is retained.
- `abort` and `start` asserted together: `abort` wins.
- `busy`=1 in RESET, WARMUP, RUN and NEXT. `done`=1 only in DONE.
- Tick counter width: $clog2(max(WARMUP_TICKS,RUN_TICKS)). Prescaler width: $clog2(PRESCALER).

## Timing
- Reset values: state IDLE, `tester_rst`=all 1, `tester_ce`=0, `cur_ch`=0, `busy`=0, `done`=0, `fail_mask`=0, counters 0.
- All outputs are registered; no combinational path from inputs to outputs.
- `busy` rises 1 clock after `start` is sampled.
- Per-channel duration: RST_CYCLES + (WARMUP_TICKS+RUN_TICKS)·PRESCALER + 1 clocks.
- `done` rises and `busy` falls on the same clock, NUM_CH × per-channel duration after `busy` rose.
- First `tester_ce` pulse occurs PRESCALER clocks after WARMUP entry.
- Exactly WARMUP_TICKS+RUN_TICKS pulses are produced per channel.
- `err_in` is registered once before sampling. An error at the last RUN clock lands in `fail_mask` during NEXT. An error at the first WARMUP clock is ignored.
- `rst_n` deassertion is synchronized internally (2-flop) before the FSM leaves IDLE.

## Configuration
- `SRL_SCHED_LOOP_EN`:
  - Defined: NEXT after the last channel goes to RESET with `cur_ch`=0 instead of DONE. `fail_mask` is not cleared, so it accumulates across sweeps. `done` pulses for 1 clock at each wrap. `busy` stays 1 until `abort`.
  - Undefined: single sweep; DONE is held as specified above.

## Structure
- Package `srl_sched_pkg`: state enum typedef (IDLE, RESET, WARMUP, RUN, NEXT, DONE) and default parameter constants.
- One sub-module, `srl_sched_prescaler`: counter with synchronous clear, enable and `tick` output, instantiated once.

## Test plan
Bench configuration: NUM_CH=4, PRESCALER=4, RST_CYCLES=4, WARMUP_TICKS=8, RUN_TICKS=16; per-channel duration is 101 clocks.
- Clean sweep: `start` pulse, `err_in`=0 → `busy` for 404 clocks, then `done`=1, `fail_mask`=4'b0000, and 24 `tester_ce` pulses per channel.
- Warm-up error: `err_in[2]`=1 for 1 clock during ch2 WARMUP → `fail_mask`=4'b0000.
- Run error: `err_in[1]`=1 during ch1 RUN, plus `err_in[3]` held high throughout → `fail_mask`=4'b1010.
- Abort: `abort` during ch2 RUN → next clock IDLE, `tester_rst`=4'b1111, `fail_mask` retained. A new `start` clears `fail_mask`.
- Start while busy, and start with abort together: `start` during ch1 is ignored; `start`+`abort` together → IDLE.
- Async reset mid-RUN: `rst_n`=0 → all outputs return to reset values immediately, without waiting for `clk`. With `SRL_SCHED_LOOP_EN`: `done` pulses every 404 clocks and `fail_mask` persists across wraps.
